// File: rtl/disp_scan_ctrl.sv
// Scan controller for a shared seven-segment decoder: sequential binary-to-BCD conversion plus
// time-multiplexed digit refresh. Define DISP_LZB_EN to enable leading-zero blanking.
module disp_scan_ctrl #(
  parameter int unsigned NDIG        = 3,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              ovf,
  output logic [3:0]        digit_bcd,
  output logic              seg_cs,
  output logic              seg_clear,
  output logic [NDIG-1:0]   dig_en
);

  localparam int unsigned BcdW  = 4 * NDIG;
  localparam int unsigned CntW  = $clog2(DATA_W + 1);
  localparam int unsigned SlotW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW  = (NDIG > 1) ? $clog2(NDIG) : 1;

  function automatic logic [63:0] pow10(int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] Pow10 = pow10(NDIG);

  typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      bin_q, bin_d;
  logic [BcdW-1:0]        bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   lost_q, lost_d;
  logic                   big_q, big_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q, ovf_d;
  logic [NDIG-1:0][3:0]   disp_q, disp_d;

  logic [SlotW-1:0]       slot_q, slot_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   slot_wrap;
  logic                   lz_blank;
  logic [3:0]             digit_bcd_q, digit_bcd_d;
  logic                   seg_cs_q, seg_cs_d;
  logic                   seg_clear_q, seg_clear_d;
  logic [NDIG-1:0]        dig_en_q, dig_en_d;

  // Converter: double-dabble, one bit per cycle.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    big_d   = big_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      StIdle: begin
        if (load) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          lost_d  = 1'b0;
          big_d   = 64'(value) >= Pow10;
          busy_d  = 1'b1;
          state_d = StConvert;
        end
      end
      StConvert: begin
        {bcd_d, bin_d} = {bcd_adj[BcdW-2:0], bin_q, 1'b0};
        // Anything leaving the top nibble means the value did not fit.
        lost_d = lost_q | bcd_adj[BcdW-1];
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_W - 1)) state_d = StCommit;
      end
      StCommit: begin
        ovf_d   = lost_q | big_q;
        disp_d  = (lost_q | big_q) ? {NDIG{4'd9}} : bcd_q;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
      big_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      big_q   <= big_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
    end
  end

  // Scanner: outputs change only on slot entry, so a slot never tears.
  always_comb begin
    slot_wrap   = (slot_q == SlotW'(REFRESH_DIV - 1));
    slot_d      = slot_wrap ? '0 : slot_q + SlotW'(1);
    idx_d       = idx_q;
    if (slot_wrap) idx_d = (idx_q == IdxW'(NDIG - 1)) ? '0 : idx_q + IdxW'(1);

    lz_blank = 1'b0;
`ifdef DISP_LZB_EN
    if (idx_q != '0) begin
      lz_blank = 1'b1;
      for (int unsigned j = 0; j < NDIG; j++) begin
        if (j >= 32'(idx_q) && disp_q[j] != 4'd0) lz_blank = 1'b0;
      end
    end
`endif

    digit_bcd_d = digit_bcd_q;
    seg_cs_d    = seg_cs_q;
    seg_clear_d = seg_clear_q;
    dig_en_d    = dig_en_q;
    if (slot_wrap) begin
      seg_cs_d    = 1'b1;
      seg_clear_d = 1'b1;
      dig_en_d    = '1;
    end else if (slot_q == '0) begin
      digit_bcd_d = disp_q[idx_q];
      seg_cs_d    = 1'b0;
      seg_clear_d = lz_blank;
      dig_en_d    = lz_blank ? '1 : ~(NDIG'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= '0;
      idx_q       <= '0;
      digit_bcd_q <= 4'd0;
      seg_cs_q    <= 1'b1;
      seg_clear_q <= 1'b1;
      dig_en_q    <= '1;
    end else begin
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      digit_bcd_q <= digit_bcd_d;
      seg_cs_q    <= seg_cs_d;
      seg_clear_q <= seg_clear_d;
      dig_en_q    <= dig_en_d;
    end
  end

  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign digit_bcd = digit_bcd_q;
  assign seg_cs    = seg_cs_q;
  assign seg_clear = seg_clear_q;
  assign dig_en    = dig_en_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: a 3-digit and a 2-digit instance share stimulus and are checked
// against a decimal-arithmetic model of the committed value and the scan schedule.
module tb_disp_scan_ctrl;

  localparam int RD = 4;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] value;

  logic       a_busy, a_ovf, a_seg_cs, a_seg_clear;
  logic [3:0] a_digit_bcd;
  logic [2:0] a_dig_en;
  logic       b_busy, b_ovf, b_seg_cs, b_seg_clear;
  logic [3:0] b_digit_bcd;
  logic [1:0] b_dig_en;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int mval;

  disp_scan_ctrl #(.NDIG(3), .DATA_W(DW), .REFRESH_DIV(RD)) dut_a (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(a_busy), .ovf(a_ovf), .digit_bcd(a_digit_bcd),
    .seg_cs(a_seg_cs), .seg_clear(a_seg_clear), .dig_en(a_dig_en)
  );

  disp_scan_ctrl #(.NDIG(2), .DATA_W(DW), .REFRESH_DIV(RD)) dut_b (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(b_busy), .ovf(b_ovf), .digit_bcd(b_digit_bcd),
    .seg_cs(b_seg_cs), .seg_clear(b_seg_clear), .dig_en(b_dig_en)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; the scan position follows from this alone.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int pow10(int n);
    int p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [3:0] exp_digit(int v, int nd, int i);
    if (v >= pow10(nd)) return 4'd9;
    return 4'((v / pow10(i)) % 10);
  endfunction

  function automatic logic exp_blank(int v, int i);
`ifdef DISP_LZB_EN
    return (i > 0) && (v < pow10(i));
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_scan(input int ncyc);
    int         slot, ia, ib;
    logic       bla, blb;
    logic [4:0] exp_a, got_a;
    logic [3:0] exp_b, got_b;
    logic [3:0] da, db;
    for (int k = 0; k < ncyc; k++) begin
      slot = cyc % RD;
      ia   = (cyc / RD) % 3;
      ib   = (cyc / RD) % 2;
      bla  = exp_blank(mval, ia);
      blb  = exp_blank(mval, ib);
      da   = exp_digit(mval, 3, ia);
      db   = exp_digit(mval, 2, ib);
      if (slot == 0) begin
        exp_a = 5'b11111;
        exp_b = 4'b1111;
      end else begin
        exp_a = {3'b111, 1'b0, bla};
        exp_b = {2'b11, 1'b0, blb};
        if (!bla) exp_a[2 + ia] = 1'b0;
        if (!blb) exp_b[2 + ib] = 1'b0;
      end
      got_a = {a_dig_en, a_seg_cs, a_seg_clear};
      got_b = {b_dig_en, b_seg_cs, b_seg_clear};
      n_tests++;
      if (got_a !== exp_a || (slot != 0 && a_digit_bcd !== da)) begin
        n_fail++;
        $display("FAIL scan_a cyc=%0d val=%0d: got en/cs/clr=%b digit=%0d, expected %b digit=%0d",
                 cyc, mval, got_a, a_digit_bcd, exp_a, da);
      end
      n_tests++;
      if (got_b !== exp_b || (slot != 0 && b_digit_bcd !== db)) begin
        n_fail++;
        $display("FAIL scan_b cyc=%0d val=%0d: got en/cs/clr=%b digit=%0d, expected %b digit=%0d",
                 cyc, mval, got_b, b_digit_bcd, exp_b, db);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_ovf();
    n_tests++;
    if (a_ovf !== (mval >= 1000) || b_ovf !== (mval >= 100)) begin
      n_fail++;
      $display("FAIL ovf val=%0d: got a=%b b=%b, expected a=%b b=%b",
               mval, a_ovf, b_ovf, mval >= 1000, mval >= 100);
    end
  endtask

  // Called at a negedge with the converter idle; returns at the first negedge with busy low.
  task automatic load_and_wait(input int v, output int n);
    load  = 1'b1;
    value = 8'(v);
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_busy_len(input string name, input int n);
    n_tests++;
    if (n != DW + 1) begin
      n_fail++;
      $display("FAIL %s busy cycles: got %0d, expected %0d", name, n, DW + 1);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({a_busy, a_ovf, a_dig_en, a_digit_bcd, a_seg_cs, a_seg_clear} !== 11'b00_111_0000_11) begin
      n_fail++;
      $display("FAIL reset_a: got %b, expected %b",
               {a_busy, a_ovf, a_dig_en, a_digit_bcd, a_seg_cs, a_seg_clear}, 11'b00_111_0000_11);
    end
    n_tests++;
    if ({b_busy, b_ovf, b_dig_en, b_digit_bcd, b_seg_cs, b_seg_clear} !== 10'b00_11_0000_11) begin
      n_fail++;
      $display("FAIL reset_b: got %b, expected %b",
               {b_busy, b_ovf, b_dig_en, b_digit_bcd, b_seg_cs, b_seg_clear}, 10'b00_11_0000_11);
    end
  endtask

  task automatic test_convert(input int v);
    int n;
    load_and_wait(v, n);
    check_busy_len("convert", n);
    mval = v;
    check_ovf();
    repeat (RD + 1) @(negedge clk);
    check_scan(2 * 3 * RD);
  endtask

  task automatic test_back_to_back();
    int v1, v2, n;
    v1 = int'($urandom_range(0, 255));
    v2 = (v1 + 1 + int'($urandom_range(0, 253))) % 256;
    load  = 1'b1;
    value = 8'(v1);
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 50) begin
      n++;
      load  = (n == 2);
      value = 8'(v2);
      @(negedge clk);
    end
    load = 1'b0;
    check_busy_len("back_to_back", n);
    mval = v1;
    check_ovf();
    repeat (RD + 1) @(negedge clk);
    check_scan(2 * 3 * RD);
  endtask

  task automatic test_reload_immediate();
    int v1, v2, n;
    v1 = int'($urandom_range(0, 255));
    v2 = int'($urandom_range(0, 255));
    load_and_wait(v1, n);
    check_busy_len("reload_first", n);
    load  = 1'b1;
    value = 8'(v2);
    @(negedge clk);
    load = 1'b0;
    n_tests++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_accept: got busy a=%b b=%b, expected 1 1", a_busy, b_busy);
    end
    n = 0;
    while (a_busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_busy_len("reload_second", n);
    mval = v2;
    check_ovf();
    repeat (RD + 1) @(negedge clk);
    check_scan(2 * 3 * RD);
  endtask

  task automatic test_reset_mid();
    load  = 1'b1;
    value = 8'd200;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy_before: got %b, expected 1", a_busy);
    end
    #2 rst = 1'b1;
    #1;
    test_reset();
    mval = 0;
    @(negedge clk);
    rst = 1'b0;
    check_ovf();
    check_scan(2 * 3 * RD);
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = 8'd0;
    mval  = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    check_scan(3 * RD);
    test_convert(37);
    test_convert(255);
    test_convert(5);
    test_convert(99);
    test_convert(100);
    test_convert(10);
    for (int i = 0; i < 6; i++) test_convert(int'($urandom_range(0, 255)));
    test_back_to_back();
    test_reload_immediate();
    test_reset_mid();
    test_convert(int'($urandom_range(0, 255)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
